// File: rtl/gf_pkg.sv
// gf_pkg: shared FSM encoding, field-degree limits and constants for gf_pow_seq
package gf_pkg;
  localparam int MAXM = 4;
  localparam logic [2:0] M3 = 3'd3;
  localparam logic [2:0] M4 = 3'd4;
  localparam logic [3:0] ONE = 4'b0001;
  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;
endpackage

// File: rtl/gf_mul_core.sv
// gf_mul_core: combinational GF(2^m) product a*b mod p for m in {3,4}; in a,b,p,m, out y
module gf_mul_core
  import gf_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [4:0] p,
  input  logic [2:0] m,
  output logic [3:0] y
);
  logic [4:0] r;
  logic [4:0] pm;
  assign pm = (m == M3) ? {1'b0, p[3:0]} : p;
  always_comb begin
    r = '0;
    for (int j = 3; j >= 0; j--) begin
      r = {r[3:0], 1'b0};
      r = ((m == M3) ? r[3] : r[4]) ? r ^ pm : r;
      r = b[j] ? r ^ {1'b0, a} : r;
    end
  end
  assign y = r[3:0];
endmodule

// File: rtl/gf_pow_seq.sv
// gf_pow_seq: MSB-first square-and-multiply a^e mod p; in start/a/e/p/m, out y/busy/done/err
module gf_pow_seq #(
  parameter int MAXM = gf_pkg::MAXM
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [MAXM-1:0] a,
  input  logic [MAXM-1:0] e,
  input  logic [MAXM:0]   p,
  input  logic [2:0]      m,
  output logic [MAXM-1:0] y,
  output logic            busy,
  output logic            done,
  output logic            err
);
  import gf_pkg::*;
  state_t state_q;
  logic [3:0] acc_q, a_q, e_q, y_q;
  logic [4:0] p_q;
  logic [2:0] m_q;
  logic [1:0] i_q;
  logic busy_q, done_q, err_q;
  logic [3:0] mul_b, prod, acc_d;
  logic legal;
  assign legal = (m == M3) || (m == M4);
  assign mul_b = (state_q == SQR) ? acc_q : a_q;
  assign acc_d = e_q[i_q] ? prod : acc_q;
  gf_mul_core u_mul (
    .a(acc_q),
    .b(mul_b),
    .p(p_q),
    .m(m_q),
    .y(prod)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      e_q     <= '0;
      p_q     <= '0;
      m_q     <= '0;
      i_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && legal) begin
            state_q <= SQR;
            acc_q   <= ONE;
            i_q     <= 2'd3;
            a_q     <= (m == M3) ? {1'b0, a[2:0]} : a;
            p_q     <= (m == M3) ? {1'b0, p[3:0]} : p;
            e_q     <= e;
            m_q     <= m;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else if (start) begin
            state_q <= DONE;
            y_q     <= '0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        SQR: begin
          acc_q   <= prod;
          state_q <= MUL;
        end
        MUL: begin
          acc_q <= acc_d;
          if (i_q == 2'd0) begin
            state_q <= DONE;
            y_q     <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            i_q     <= i_q - 2'd1;
            state_q <= SQR;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
endmodule

// File: tb/tb_gf_pow_seq.sv
// tb_gf_pow_seq: directed self-checking bench for gf_pow_seq
module tb_gf_pow_seq;
  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] a, e, y;
  logic [4:0] p;
  logic [2:0] m;
  logic busy, done, err;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  gf_pow_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .e(e), .p(p), .m(m),
    .y(y), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n, output logic bs);
    n = 0;
    bs = busy;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      bs = bs | busy;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] ai, input logic [3:0] ei,
                        input logic [4:0] pi, input logic [2:0] mi,
                        input logic [3:0] ey, input logic eerr);
    int n;
    logic bs;
    @(negedge clk);
    a = ai; e = ei; p = pi; m = mi; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 4'($urandom); e = 4'($urandom); p = 5'($urandom); m = 3'($urandom);
    wait_done(n, bs);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(n), eerr ? 32'd0 : 32'd8);
    chk({tag, "_y"}, 32'(y), 32'(ey));
    chk({tag, "_err"}, 32'(err), 32'(eerr));
    chk({tag, "_busy"}, 32'(bs), 32'(!eerr));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(y), 32'(ey));
  endtask

  initial begin
    int n, c0, c1, c2;
    logic bs;
    rst = 1'b1; start = 1'b0; a = '0; e = '0; p = '0; m = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("m4_a2_e4", 4'd2, 4'd4, 5'b10011, 3'd4, 4'd3, 1'b0);
    run_op("m4_a2_e14", 4'd2, 4'd14, 5'b10011, 3'd4, 4'd9, 1'b0);
    run_op("m4_a2_e15", 4'd2, 4'd15, 5'b10011, 3'd4, 4'd1, 1'b0);
    run_op("m4_a3_e2", 4'd3, 4'd2, 5'b10011, 3'd4, 4'd5, 1'b0);
    run_op("m4_a7_e3", 4'd7, 4'd3, 5'b10011, 3'd4, 4'd1, 1'b0);
    run_op("m4_a0_e5", 4'd0, 4'd5, 5'b10011, 3'd4, 4'd0, 1'b0);
    run_op("m3_a3_e6", 4'd3, 4'd6, 5'b01011, 3'd3, 4'd6, 1'b0);
    run_op("m3_a2_e3", 4'd2, 4'd3, 5'b01011, 3'd3, 4'd3, 1'b0);
    run_op("m3_a0_e0", 4'd0, 4'd0, 5'b01011, 3'd3, 4'd1, 1'b0);
    run_op("m3_a5_e2", 4'd5, 4'd2, 5'b01011, 3'd3, 4'd7, 1'b0);
    run_op("m3_amask", 4'b1010, 4'd1, 5'b01011, 3'd3, 4'd2, 1'b0);
    run_op("m3_pmask", 4'd2, 4'd3, 5'b11011, 3'd3, 4'd3, 1'b0);
    run_op("m5_illegal", 4'd7, 4'd9, 5'b10011, 3'd5, 4'd0, 1'b1);
    run_op("m0_illegal", 4'd1, 4'd0, 5'b10011, 3'd0, 4'd0, 1'b1);
    run_op("err_clear", 4'd2, 4'd4, 5'b10011, 3'd4, 4'd3, 1'b0);

    @(negedge clk);
    a = 4'd3; e = 4'd7; p = 5'b10011; m = 3'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_abort", 4'd2, 4'd4, 5'b10011, 3'd4, 4'd3, 1'b0);

    @(negedge clk);
    a = 4'd2; e = 4'd4; p = 5'b10011; m = 3'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 4'd2; e = 4'd14;
    wait_done(n, bs);
    c0 = cyc;
    chk("str1_lat", 32'(n), 32'd8);
    chk("str1_y", 32'(y), 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 4'd3; e = 4'd6; p = 5'b01011; m = 3'd3;
    wait_done(n, bs);
    c1 = cyc;
    chk("str2_y", 32'(y), 32'd9);
    chk("str2_period", 32'(c1 - c0), 32'd10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 4'd15; e = 4'd15; p = 5'b10011; m = 3'd4;
    wait_done(n, bs);
    c2 = cyc;
    chk("str3_y", 32'(y), 32'd6);
    chk("str3_period", 32'(c2 - c1), 32'd10);
    repeat (12) @(posedge clk);
    #1;
    chk("str_idle_done", 32'(done), 32'd0);
    chk("str_idle_busy", 32'(busy), 32'd0);
    chk("str_idle_y", 32'(y), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gf_pow_seq.md
GF_POW_SEQ -- requirements
Module: gf_pow_seq

Interface
REQ-001 Parameter MAXM, default 4, maximum supported field degree; operand width is MAXM bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  4  base field element.
REQ-006 e  input  4  exponent, unsigned.
REQ-007 p  input  5  irreducible polynomial, bit i = coeff of x^i (m=3: p[4]=0).
REQ-008 m  input  3  field degree; legal values 3 and 4.
REQ-009 y  output  4  result a^e in GF(2^m); held until next accepted start.
REQ-010 busy  output  1  high while computing.
REQ-011 done  output  1  one-cycle pulse when y valid.
REQ-012 err  output  1  high with done when m was illegal; held until next accepted start.

Function
REQ-013 Computes y = a^e mod p by MSB-first square-and-multiply; a^0 = 1 for every a, including a=0.
REQ-014 On an accepted start, a, e, p and m are latched; later input changes do not affect the operation.
REQ-015 For m=3, latched a[3] and p[4] are forced to 0; y[3] is always 0.
REQ-016 States: IDLE, SQR, MUL, DONE.
REQ-017 IDLE: start=1 with legal m -> SQR, acc=1, bit index i=3; start=1 with illegal m -> DONE, err=1, y=0; else stay.
REQ-018 SQR: acc <= acc*acc mod p -> MUL.
REQ-019 MUL: if e[i]=1, acc <= acc*a mod p, else acc holds; if i=0 -> DONE and y <= result, else i <= i-1 -> SQR.
REQ-020 DONE: done=1 for exactly one cycle -> IDLE.
REQ-021 Fixed latency: start sampled at edge k (legal m), 8 compute edges k+1..k+8, done high in the cycle after edge k+8; illegal m: done high in the cycle after edge k.
REQ-022 busy=1 in SQR and MUL only; start while busy or in DONE is ignored, not queued.
REQ-023 All multiplies use one shared GF multiplier instance; products reduced modulo p to m bits; no results wider than m bits leave the block.
REQ-024 Back-to-back: start asserted in the IDLE cycle right after DONE is accepted.

Reset
REQ-025 rst=1 forces IDLE immediately regardless of state; y=0, busy=0, done=0, err=0, acc=0, i=0.
REQ-026 Reset mid-operation aborts it with no done pulse; the first start after rst deasserts is treated as fresh.

Structure
REQ-027 A shared package gf_pkg holds the state encoding, MAXM, the legal-m constants (3, 4) and the constant ONE=4'b0001.
REQ-028 One sub-module, gf_mul_core: combinational a*b mod p for m in {3,4}, inputs a,b[3:0], p[4:0], m[2:0], output [3:0].
REQ-029 Only the FSM, acc, i and latched operands are registered; gf_mul_core has no state.

Verification
REQ-030 m=4, p=5'b10011, a=2, e=4 -> done after 8 edges, y=3, err=0.
REQ-031 m=4, p=5'b10011, a=2, e=14 -> y=9 (inverse of x); a=2, e=15 -> y=1.
REQ-032 m=3, p=5'b01011, a=3, e=6 -> y=6 (inverse); a=2, e=3 -> y=3; a=0, e=0 -> y=1.
REQ-033 m=5, any operands -> done after one edge, err=1, y=0, busy never high.
REQ-034 rst pulsed at compute edge 4, then a new start (m=4, p=5'b10011, a=2, e=4) -> no done pulse from the aborted run, y=3 after 8 edges.
REQ-035 start held high continuously, inputs changed during busy -> one done per 10 cycles, each y matching the operands latched at its start.
